// File: rtl/quad_pkg.sv
// ============================================================================
// quad_pkg : shared types, constants and the quadrature step table
// Revision : 1.0
// ============================================================================
`default_nettype none

package quad_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_DEPTH  = 3;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef logic [1:0] phase_t;

  // Forward (up) successor of an {A,B} sample: 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t fwd_next(input phase_t ab);
    phase_t nxt;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_decoder_if.sv
// ============================================================================
// quad_decoder_if : encoder phases, controls and decoded position outputs
// Revision : 1.0
// ============================================================================
`default_nettype none

interface quad_decoder_if #(
  parameter int CNT_W = 8
) ();

  logic             enable;
  logic             clear;
  logic             phase_a;
  logic             phase_b;
  logic [CNT_W-1:0] count;
  logic             up_pulse;
  logic             down_pulse;
  logic             dir;
  logic             err;

  modport master (
    output enable, clear, phase_a, phase_b,
    input  count, up_pulse, down_pulse, dir, err
  );

  modport slave (
    input  enable, clear, phase_a, phase_b,
    output count, up_pulse, down_pulse, dir, err
  );

endinterface

`default_nettype wire

// File: rtl/quad_phase_sync.sv
// ============================================================================
// quad_phase_sync : 2-flop synchronizer for one encoder phase, optionally
//                   followed by a 3-sample stability filter (QUAD_DECODER_FILTER_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

module quad_phase_sync
  import quad_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic phase_i,
  output logic phase_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], phase_i};
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];

`ifdef QUAD_DECODER_FILTER_EN
  logic [FILT_DEPTH-2:0] hist_q;
  logic                  filt_q;
  logic                  filt_d;

  // Current sample plus the two held ones form the three-sample window
  always_comb begin
    filt_d = filt_q;
    if (hist_q == {(FILT_DEPTH-1){w_sync}}) begin
      filt_d = w_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[FILT_DEPTH-3:0], w_sync};
      filt_q <= filt_d;
    end
  end

  assign phase_o = filt_d;
`else
  assign phase_o = w_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
// quad_decoder : quadrature encoder decoder with wrapping position counter,
//                step strobes and sticky error; QUAD_DECODER_FILTER_EN adds filter
// Revision : 1.0
// ============================================================================
`default_nettype none

module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  quad_decoder_if.slave  bus
);

`ifdef QUAD_DECODER_FILTER_EN
  localparam int INIT_CYCLES = SYNC_STAGES + FILT_DEPTH - 1;
`else
  localparam int INIT_CYCLES = SYNC_STAGES;
`endif
  localparam logic [2:0] INIT_LAST = 3'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_a;
  logic             w_b;
  phase_t           w_ab;

  state_t           state_q, state_d;
  logic [2:0]       init_cnt_q, init_cnt_d;
  phase_t           prev_ab_q, prev_ab_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             w_step_up;
  logic             w_step_dn;
  logic             w_jump;

  quad_phase_sync u_sync_a (
    .clk     (clk),
    .reset   (reset),
    .phase_i (bus.phase_a),
    .phase_o (w_a)
  );

  quad_phase_sync u_sync_b (
    .clk     (clk),
    .reset   (reset),
    .phase_i (bus.phase_b),
    .phase_o (w_b)
  );

  assign w_ab = {w_a, w_b};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_ab_d  = prev_ab_q;
    count_d    = count_q;
    dir_d      = dir_q;
    err_d      = err_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    w_step_up  = (w_ab == fwd_next(prev_ab_q));
    w_step_dn  = (prev_ab_q == fwd_next(w_ab));
    w_jump     = (w_ab == ~prev_ab_q);

    case (state_q)
      INIT: begin
        // Wait until the sampling pipeline holds real input before taking a reference
        if (init_cnt_q == INIT_LAST) begin
          prev_ab_d = w_ab;
          state_d   = TRACK;
        end else begin
          init_cnt_d = init_cnt_q + 3'd1;
        end
      end
      TRACK: begin
        prev_ab_d = w_ab;
        if (w_jump) begin
          err_d = 1'b1;
        end else if (bus.enable) begin
          if (w_step_up) begin
            count_d = count_q + CNT_ONE;
            dir_d   = 1'b1;
            up_d    = 1'b1;
          end else if (w_step_dn) begin
            count_d = count_q - CNT_ONE;
            dir_d   = 1'b0;
            dn_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Clear zeroes position and error but leaves this cycle's strobe and direction intact
    if (bus.clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= 3'd0;
      prev_ab_q  <= 2'b00;
      count_q    <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_ab_q  <= prev_ab_d;
      count_q    <= count_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.up_pulse   = up_q;
  assign bus.down_pulse = dn_q;
  assign bus.dir        = dir_q;
  assign bus.err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// tb_quad_decoder : scoreboard bench for quad_decoder (honours QUAD_DECODER_FILTER_EN)
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_quad_decoder;

  localparam int CNT_W = 8;
`ifdef QUAD_DECODER_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    bit             up;
    logic [CNT_W-1:0] cnt;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quad_decoder_if #(.CNT_W(CNT_W)) bus ();

  quad_decoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t             sb_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  int               n_up  = 0;
  int               n_dn  = 0;
  logic [1:0]       m_ab;
  logic [CNT_W-1:0] m_cnt;
  bit               m_dir;
  bit               m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] ab);
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.up_pulse || bus.down_pulse) begin
      if (bus.up_pulse) n_up++;
      if (bus.down_pulse) n_dn++;
      check("pulse_excl", 32'(bus.up_pulse & bus.down_pulse), 0);
      if (sb_q.size() == 0) begin
        check("unexp_pulse", 32'({bus.up_pulse, bus.down_pulse}), 0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_up", 32'(bus.up_pulse), 32'(e.up));
        check("pulse_cnt", 32'(bus.count), 32'(e.cnt));
        check("pulse_cyc", cyc, e.cyc);
        check("pulse_dir", 32'(bus.dir), 32'(e.up));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new {A,B}; model the effect and queue the expected strobe
  task automatic drive(input logic [1:0] ab, input bit clr_hit);
    exp_t e;
    bit   up;
    bus.phase_a = ab[1];
    bus.phase_b = ab[0];
    up = (ab == nxt(m_ab));
    if (ab != m_ab) begin
      if (up || (m_ab == nxt(ab))) begin
        if (bus.enable) begin
          m_cnt = clr_hit ? '0 : (up ? m_cnt + 8'd1 : m_cnt - 8'd1);
          m_dir = up;
          e.up  = up;
          e.cnt = m_cnt;
          e.cyc = cyc + LAT;
          sb_q.push_back(e);
        end
      end else begin
        m_err = 1'b1;
      end
    end
    m_ab = ab;
  endtask

  task automatic step(input logic [1:0] ab);
    drive(ab, 1'b0);
    tick(6);
  endtask

  task automatic settle();
    int t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      tick(1);
      t++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cnt"}, 32'(bus.count), 32'(m_cnt));
    check({tag, "_dir"}, 32'(bus.dir), 32'(m_dir));
    check({tag, "_err"}, 32'(bus.err), 32'(m_err));
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    m_cnt = '0;
    m_err = 1'b0;
    tick(1);
  endtask

  task automatic model_reset(input logic [1:0] ab);
    m_ab  = ab;
    m_cnt = '0;
    m_dir = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.enable  = 1'b1;
    bus.clear   = 1'b0;
    bus.phase_a = 1'b0;
    bus.phase_b = 1'b0;
    model_reset(2'b00);
    tick(4);
    check_state("reset");
    check("reset_up", 32'(bus.up_pulse), 0);
    check("reset_dn", 32'(bus.down_pulse), 0);
    reset = 1'b0;
    tick(8);

    // Four forward steps
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    check_state("fwd4");
    check("fwd4_nup", n_up, 4);
    do_clear();
    check_state("clr0");

    // Wrap below zero and back
    step(2'b10);
    check("wrap_ff", 32'(bus.count), 32'h0000_00FF);
    check_state("wrap_dn");
    step(2'b00);
    check_state("wrap_up");

    // Two-bit jump after reaching count 4
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    step(2'b11);
    check_state("jump");
    do_clear();
    check_state("jump_clr");

    // Disabled steps and disabled-mode error detection
    bus.enable = 1'b0;
    step(2'b10); step(2'b00); step(2'b01);
    check_state("en_off");
    step(2'b10);
    check_state("en_off_err");
    do_clear();
    bus.enable = 1'b1;
    step(2'b00);
    check_state("en_on");

    // Clear coinciding with a step: strobe survives, count is zeroed
    drive(2'b01, 1'b1);
    tick(LAT - 1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(5);
    check_state("clr_step");

    // Phases held at 11 through reset release
    bus.phase_a = 1'b1;
    bus.phase_b = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset(2'b11);
    tick(10);
    check_state("hold11");
    step(2'b10);
    check_state("after11");

    // One-cycle glitch on phase A from 10
`ifdef QUAD_DECODER_FILTER_EN
    bus.phase_a = 1'b0;
    tick(1);
    bus.phase_a = 1'b1;
    tick(8);
`else
    drive(2'b00, 1'b0);
    tick(1);
    drive(2'b10, 1'b0);
    tick(8);
`endif
    check_state("glitch");

    // Reset asserted while a step is still in the pipeline
    bus.phase_a = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset(2'b00);
    tick(10);
    check_state("rst_mid");
    step(2'b01);
    check_state("post_rst");

    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the position counter width (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: 1 = steps update count and pulses; 0 = steps tracked but ignored.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous count and error clear.
REQ-006 The block SHALL have ports phase_a and phase_b, inputs, 1 bit each: asynchronous quadrature encoder phases.
REQ-007 The block SHALL have port count, output, CNT_W bits: signed-agnostic position counter.
REQ-008 The block SHALL have ports up_pulse and down_pulse, outputs, 1 bit each: one-cycle step strobes.
REQ-009 The block SHALL have port dir, output, 1 bit: direction of last valid step (1 = up).
REQ-010 The block SHALL have port err, output, 1 bit: sticky illegal-transition flag.

Function
REQ-011 Phases SHALL pass through a 2-flop synchronizer per phase before any use.
REQ-012 Control FSM SHALL have states INIT and TRACK; INIT lasts until the synchronizer (and filter, if present) is full, then loads prev_ab from the sampled {A,B} and enters TRACK without counting.
REQ-013 In TRACK, forward sequence 00->01->11->10->00 ({A,B}) SHALL be an up step; reverse SHALL be a down step; no change SHALL be idle.
REQ-014 Up step with enable=1: count <= count+1 mod 2^CNT_W, up_pulse=1 for one cycle, dir<=1.
REQ-015 Down step with enable=1: count <= count-1 mod 2^CNT_W, down_pulse=1 for one cycle, dir<=0.
REQ-016 Wrap-around: all-ones +1 SHALL give 0; 0 -1 SHALL give all-ones; no saturation, no flag.
REQ-017 Two-bit change (00<->11, 01<->10) SHALL set err, leave count/dir unchanged, emit no pulse.
REQ-018 prev_ab SHALL update to the new sample on every TRACK cycle regardless of enable or err.
REQ-019 up_pulse and down_pulse SHALL never both be 1.
REQ-020 Latency: a phase edge meeting setup before rising edge N SHALL be reflected in count/pulse after edge N+2.
REQ-021 clear=1 SHALL force count=0 and err=0 that cycle, overriding any simultaneous step; pulses still reflect the step, and dir updates.
REQ-022 enable=0 SHALL suppress pulses, count and dir updates, but not err detection.

Reset
REQ-023 reset SHALL win over all inputs: count=0, up_pulse=0, down_pulse=0, dir=0, err=0, synchronizers=0, prev_ab=00, state=INIT.
REQ-024 reset asserted mid-step SHALL discard the step; after release, the INIT sequence SHALL repeat and the first sample SHALL NOT produce a step or error.

Configuration
REQ-025 Macro QUAD_DECODER_FILTER_EN defined: each synchronized phase SHALL pass a 3-sample stability filter (output changes only when 3 consecutive samples agree), adding 2 cycles latency (step after edge N+4) and extending INIT by 2 cycles.
REQ-026 Macro undefined: no filter; latency per REQ-020; single-cycle glitches surviving the synchronizer SHALL be decoded as steps.

Structure
REQ-027 A shared package quad_pkg SHALL hold the FSM state typedef (INIT, TRACK), the 2-bit phase typedef, and constants SYNC_STAGES=2 and FILT_DEPTH=3.
REQ-028 The per-phase synchronizer plus optional filter SHALL be sub-module quad_phase_sync, instantiated twice.

Verification
REQ-029 Reset, then 4 forward steps 00,01,11,10,00 spaced 5 cycles -> count=4, 4 up_pulses, dir=1, err=0.
REQ-030 From count=0, one reverse step 00->10 -> count=all-ones (8'hFF), one down_pulse, dir=0.
REQ-031 From count=8'hFF, one forward step -> count=8'h00, no err.
REQ-032 Jump 00->11 -> err=1, count unchanged; subsequent clear=1 -> err=0, count=0.
REQ-033 enable=0 during 3 forward steps -> count unchanged, no pulses; then enable=1, one forward step -> count+1.
REQ-034 Inputs held at 11 through reset release -> no step, no err; then 11->10 -> count=1; with QUAD_DECODER_FILTER_EN, 1-cycle glitch on phase_a -> no step.
